// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The master side drives restart and the PLL lock indication and observes
// the PLL reset, the core reset and the status outputs. The slave side is
// the sequencer.
interface pll_reset_sequencer_if;
  logic       restart;       // single-cycle re-sequence request
  logic       pll_locked;    // raw PLL lock, asynchronous to clk
  logic       pll_rst;       // to PLL rst, active-high
  logic       sys_reset_n;   // core reset, active-low
  logic       fail;          // sticky: retries exhausted
  logic [7:0] relock_count;  // lock losses seen in RUN, saturating
  logic [2:0] state;         // current FSM state for debug/OSD

  modport master (
    output restart, pll_locked,
    input  pll_rst, sys_reset_n, fail, relock_count, state
  );

  modport slave (
    input  restart, pll_locked,
    output pll_rst, sys_reset_n, fail, relock_count, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer, running in the 50 MHz reference domain.
// Pulses the PLL reset, waits for lock, qualifies lock as stable and only
// then releases the core reset. A lock loss in RUN re-sequences the PLL.
// Optional feature macro: PLL_LOCK_GLITCH_FILTER_EN -- when defined, a lock
// loss in RUN must persist for GLITCH_CYCLES synchronised samples.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 64,
  parameter int unsigned LOCK_STABLE_CYCLES  = 50000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 23,
  parameter int unsigned GLITCH_CYCLES       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [7:0]       r_retries;
  logic [7:0]       r_relock_count;
  logic             r_pll_rst;
  logic             r_sys_reset_n;
  logic             r_fail;
  logic             r_lock_meta;
  logic             r_lk;

  state_t           w_next_state;
  logic             w_retry_inc;
  logic             w_relock_inc;
  logic [7:0]       w_retries_next;
  logic             w_lock_loss;

  // Two-flop synchroniser bringing pll_locked into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lk        <= 1'b0;
    end else begin
      r_lock_meta <= bus.pll_locked;
      r_lk        <= r_lock_meta;
    end
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int unsigned GW = $clog2(GLITCH_CYCLES + 1);

  logic [GW-1:0] r_glitch_cnt;

  // Count consecutive lk=0 samples in RUN; any lk=1 or leaving RUN clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_glitch_cnt <= '0;
    end else if (r_state != ST_RUN || r_lk) begin
      r_glitch_cnt <= '0;
    end else if (r_glitch_cnt != GW'(GLITCH_CYCLES)) begin
      r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end
  end

  assign w_lock_loss = (r_glitch_cnt == GW'(GLITCH_CYCLES));
`else
  // Filter length has no role in this build.
  localparam int unsigned GLITCH_UNUSED = GLITCH_CYCLES;

  assign w_lock_loss = ~r_lk;
`endif

  assign w_retries_next = (r_retries == 8'hFF) ? r_retries : r_retries + 8'd1;

  // Next-state decode and the retry/relock bookkeeping strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_retry_inc  = 1'b0;
    w_relock_inc = 1'b0;
    unique case (r_state)
      ST_RESET_PLL: begin
        if (r_timer == RST_LAST) w_next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lk) begin
          w_next_state = ST_STABILIZE;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_retry_inc = 1'b1;
          if (MAX_RETRIES != 0 && w_retries_next == 8'(MAX_RETRIES))
            w_next_state = ST_FAIL;
          else
            w_next_state = ST_RESET_PLL;
        end
      end
      ST_STABILIZE: begin
        // Unfiltered in both builds: any dropout restarts the wait window.
        if (!r_lk)                      w_next_state = ST_WAIT_LOCK;
        else if (r_timer == STABLE_LAST) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_lock_loss) begin
          w_next_state = ST_RESET_PLL;
          w_relock_inc = 1'b1;
        end
      end
      ST_FAIL: begin
        w_next_state = ST_FAIL;
      end
      default: begin
        w_next_state = ST_RESET_PLL;
      end
    endcase
    // Restart wins over everything, including a coincident lock loss.
    if (bus.restart) begin
      w_next_state = ST_RESET_PLL;
      w_retry_inc  = 1'b0;
      w_relock_inc = 1'b0;
    end
  end

  // State register, timer, counters and outputs decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_state        <= ST_RESET_PLL;
      r_timer        <= '0;
      r_retries      <= '0;
      r_relock_count <= '0;
      r_pll_rst      <= 1'b1;
      r_sys_reset_n  <= 1'b0;
      r_fail         <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (bus.restart || w_next_state != r_state) r_timer <= '0;
      else if (r_timer != '1)                      r_timer <= r_timer + 1'b1;

      if (bus.restart || (r_state == ST_STABILIZE && w_next_state == ST_RUN))
        r_retries <= '0;
      else if (w_retry_inc)
        r_retries <= w_retries_next;

      if (w_relock_inc && r_relock_count != 8'hFF)
        r_relock_count <= r_relock_count + 8'd1;

      r_pll_rst     <= (w_next_state == ST_RESET_PLL) || (w_next_state == ST_FAIL);
      r_sys_reset_n <= (w_next_state == ST_RUN);
      r_fail        <= (w_next_state == ST_FAIL);
    end
  end

  assign bus.pll_rst      = r_pll_rst;
  assign bus.sys_reset_n  = r_sys_reset_n;
  assign bus.fail         = r_fail;
  assign bus.relock_count = r_relock_count;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
// Inputs change 1 ns after a rising edge; outputs are observed at that point,
// i.e. the value each register took on the edge just passed.
module tb_pll_reset_sequencer;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int LOSS_LAT  = 6;  // 2 sync + 3 filter + 1
  localparam bit FILTER_ON = 1'b1;
`else
  localparam int LOSS_LAT  = 3;  // 2 sync + 1
  localparam bit FILTER_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_failures = 0;

  pll_reset_sequencer_if bus_if ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (10),
    .LOCK_TIMEOUT_CYCLES(50),
    .MAX_RETRIES        (2),
    .CNT_W              (23),
    .GLITCH_CYCLES      (3)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic prst,
                            input logic srn, input logic fl);
    check({tag, ".state"},       32'(bus_if.state),       32'(st));
    check({tag, ".pll_rst"},     32'(bus_if.pll_rst),     32'(prst));
    check({tag, ".sys_reset_n"}, 32'(bus_if.sys_reset_n), 32'(srn));
    check({tag, ".fail"},        32'(bus_if.fail),        32'(fl));
  endtask

  // Restart pulse from the current point; never-lock run ending in FAIL.
  task automatic never_lock_to_fail(input string tag);
    tick(3);  check_outs({tag, "_p1_end"},   3'd0, 1'b1, 1'b0, 1'b0);
    tick(1);  check_outs({tag, "_wait1"},    3'd1, 1'b0, 1'b0, 1'b0);
    tick(49); check_outs({tag, "_wait1_end"},3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs({tag, "_p2"},       3'd0, 1'b1, 1'b0, 1'b0);
    tick(3);  check_outs({tag, "_p2_end"},   3'd0, 1'b1, 1'b0, 1'b0);
    tick(1);  check_outs({tag, "_wait2"},    3'd1, 1'b0, 1'b0, 1'b0);
    tick(49); check_outs({tag, "_wait2_end"},3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs({tag, "_fail"},     3'd4, 1'b1, 1'b0, 1'b1);
    tick(5);  check_outs({tag, "_fail_hold"},3'd4, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n           = 1'b0;
    bus_if.restart    = 1'b0;
    bus_if.pll_locked = 1'b0;

    // Reset values.
    tick(2);
    check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    check("reset.relock", 32'(bus_if.relock_count), 32'd0);
    reset_n = 1'b1;

    // 1. Nominal: pll_rst high for exactly 4 cycles, lock at cycle 20.
    tick(3);  check_outs("nom_pulse_end", 3'd0, 1'b1, 1'b0, 1'b0);
    tick(1);  check_outs("nom_wait",      3'd1, 1'b0, 1'b0, 1'b0);
    tick(16); bus_if.pll_locked = 1'b1;               // cycle 20
    tick(2);  check_outs("nom_sync",      3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("nom_stab",      3'd2, 1'b0, 1'b0, 1'b0);
    tick(9);  check_outs("nom_stab_end",  3'd2, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("nom_run",       3'd3, 1'b0, 1'b1, 1'b0);   // cycle 33

    // 4/5. Single-cycle lock drop in RUN.
    bus_if.pll_locked = 1'b0;
    tick(1);  bus_if.pll_locked = 1'b1;
    if (!FILTER_ON) begin
      tick(1); check_outs("drop1_pre",  3'd3, 1'b0, 1'b1, 1'b0);
      tick(1); check_outs("drop1_loss", 3'd0, 1'b1, 1'b0, 1'b0);
    end else begin
      tick(6); check_outs("drop1_ignored", 3'd3, 1'b0, 1'b1, 1'b0);
      check("drop1_ignored.relock", 32'(bus_if.relock_count), 32'd0);
      // 3-cycle drop: loss after 6 cycles.
      bus_if.pll_locked = 1'b0;
      tick(3); bus_if.pll_locked = 1'b1;
      tick(2); check_outs("drop3_pre",  3'd3, 1'b0, 1'b1, 1'b0);
      tick(1); check_outs("drop3_loss", 3'd0, 1'b1, 1'b0, 1'b0);
    end
    check("loss.relock", 32'(bus_if.relock_count), 32'd1);
    tick(3);  check_outs("relock_pulse_end", 3'd0, 1'b1, 1'b0, 1'b0);
    tick(1);  check_outs("relock_wait",      3'd1, 1'b0, 1'b0, 1'b0);
    tick(11); check_outs("relock_run",       3'd3, 1'b0, 1'b1, 1'b0);

    // Restart coincident with lock loss: restart wins, relock_count kept.
    bus_if.pll_locked = 1'b0;
    tick(LOSS_LAT - 1);
    check_outs("coinc_pre", 3'd3, 1'b0, 1'b1, 1'b0);
    bus_if.restart = 1'b1;
    tick(1);  bus_if.restart = 1'b0;
    check_outs("coinc_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    check("coinc.relock", 32'(bus_if.relock_count), 32'd1);

    // 2. Never lock: two pulses 54 cycles apart, then FAIL.
    never_lock_to_fail("nolock");

    // 6. Restart out of FAIL; a fresh two-timeout run proves retries cleared.
    bus_if.restart = 1'b1;
    tick(1);  bus_if.restart = 1'b0;
    check_outs("fail_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    check("fail_restart.relock", 32'(bus_if.relock_count), 32'd1);
    never_lock_to_fail("nolock2");

    // 3. Unstable lock: high 5, low 1, then high.
    bus_if.restart = 1'b1;
    tick(1);  bus_if.restart = 1'b0;                  // edge P
    check_outs("unst_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    tick(5);  bus_if.pll_locked = 1'b1;               // P+5
    tick(5);  bus_if.pll_locked = 1'b0;               // P+10
    tick(1);  bus_if.pll_locked = 1'b1;               // P+11, final rise
    tick(1);  check_outs("unst_stab",    3'd2, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("unst_back",    3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("unst_stab2",   3'd2, 1'b0, 1'b0, 1'b0);
    tick(9);  check_outs("unst_pre_run", 3'd2, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("unst_run",     3'd3, 1'b0, 1'b1, 1'b0);   // final rise + 13

    // Restart from RUN with lock held, then reset_n mid-STABILIZE.
    bus_if.restart = 1'b1;
    tick(1);  bus_if.restart = 1'b0;
    check_outs("run_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    check("run_restart.relock", 32'(bus_if.relock_count), 32'd1);
    tick(4);  check_outs("rs_wait", 3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);  check_outs("rs_stab", 3'd2, 1'b0, 1'b0, 1'b0);
    tick(2);  reset_n = 1'b0;
    tick(1);  check_outs("mid_reset", 3'd0, 1'b1, 1'b0, 1'b0);
    check("mid_reset.relock", 32'(bus_if.relock_count), 32'd0);
    reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
